instr_cache_line_fetch: RTL and testbench

- Memory-side refill engine for the direct-mapped instruction cache.
- Driven by the instruction cache FSM: start_read is held high for the whole ALLOCATE state, and r_last is returned to it.
- On a miss it issues one AXI4 INCR read burst for the whole cache line and assembles the returned beats into a line register.
- It then pulses r_last for exactly one cycle with the full line valid, so the cache array is written in that same cycle.

---
 rtl/instr_cache_line_fetch_if.sv | 36 +++
 rtl/instr_cache_line_fetch.sv | 90 +++++++++
 tb/tb_instr_cache_line_fetch.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_cache_line_fetch_if.sv
// Bundle between the instruction-cache FSM / AXI read channels and the line refill engine.
// The master modport is the refill engine; the slave modport is the cache FSM plus memory side.
interface instr_cache_line_fetch_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
);
  logic                              i_start_read;
  logic [ADDR_WIDTH-1:0]             i_addr;
  logic                              o_r_last;
  logic [BLOCK_WORDS*DATA_WIDTH-1:0] o_line_data;
  logic                              o_error;
  logic                              o_arvalid;
  logic                              i_arready;
  logic [ADDR_WIDTH-1:0]             o_araddr;
  logic [7:0]                        o_arlen;
  logic [2:0]                        o_arsize;
  logic [1:0]                        o_arburst;
  logic                              i_rvalid;
  logic                              o_rready;
  logic [DATA_WIDTH-1:0]             i_rdata;
  logic [1:0]                        i_rresp;
  logic                              i_rlast;

  modport master (
    input  i_start_read, i_addr, i_arready, i_rvalid, i_rdata, i_rresp, i_rlast,
    output o_r_last, o_line_data, o_error, o_arvalid, o_araddr, o_arlen, o_arsize,
           o_arburst, o_rready
  );

  modport slave (
    output i_start_read, i_addr, i_arready, i_rvalid, i_rdata, i_rresp, i_rlast,
    input  o_r_last, o_line_data, o_error, o_arvalid, o_araddr, o_arlen, o_arsize,
           o_arburst, o_rready
  );
endinterface

// File: rtl/instr_cache_line_fetch.sv
// Instruction-cache refill engine: one AXI4 INCR burst per miss, beats assembled into a line
// register, then a single-cycle r_last pulse with the whole line and a sticky error flag.
module instr_cache_line_fetch #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                     clk,
  input  logic                     arst,
  instr_cache_line_fetch_if.master bus
);
  localparam int OFF_W = $clog2(BLOCK_WORDS * DATA_WIDTH / 8);
  localparam int CNT_W = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                               state, state_nxt;
  logic [CNT_W-1:0]                     beat_cnt;
  logic                                 last_beat;
  logic                                 beat_acc;
  logic                                 error;
  logic [ADDR_WIDTH-1:0]                araddr;
  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] line;
  logic                                 arvalid, rready, r_last;
  logic                                 unused_bits;

  assign last_beat   = (beat_cnt == CNT_W'(BLOCK_WORDS - 1));
  assign beat_acc    = (state == DATA) && bus.i_rvalid;
  assign unused_bits = ^{bus.i_addr[OFF_W-1:0], bus.i_rresp[0]};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Burst length is owned by the beat counter; i_rlast only feeds the error check.
  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    r_last    = 1'b0;
    case (state)
      IDLE: if (bus.i_start_read) state_nxt = ADDR;
      ADDR: begin
        arvalid = 1'b1;
        if (bus.i_arready) state_nxt = DATA;
      end
      DATA: begin
        rready = 1'b1;
        if (bus.i_rvalid && last_beat) state_nxt = DONE;
      end
      DONE: begin
        r_last    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slots not yet written in the current burst keep the previous line's words.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      beat_cnt <= '0;
      error    <= 1'b0;
      araddr   <= '0;
      line     <= '0;
    end else begin
      if (state == IDLE && bus.i_start_read) begin
        araddr   <= {bus.i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        beat_cnt <= '0;
        error    <= 1'b0;
      end
      if (beat_acc) begin
        line[beat_cnt] <= bus.i_rdata;
        beat_cnt       <= beat_cnt + CNT_W'(1);
        if (bus.i_rresp[1] || (bus.i_rlast != last_beat)) error <= 1'b1;
      end
    end
  end

  assign bus.o_arvalid   = arvalid;
  assign bus.o_rready    = rready;
  assign bus.o_r_last    = r_last;
  assign bus.o_error     = r_last && error;
  assign bus.o_araddr    = araddr;
  assign bus.o_arlen     = 8'(BLOCK_WORDS - 1);
  assign bus.o_arsize    = 3'($clog2(DATA_WIDTH / 8));
  assign bus.o_arburst   = 2'b01;
  assign bus.o_line_data = line;
endmodule

// File: tb/tb_instr_cache_line_fetch.sv
// Bench for the refill engine: table-driven directed bursts, a mid-burst reset, then random bursts
// checked against a line/error model built from the beat sequence.
module tb_instr_cache_line_fetch;
  localparam int AW     = 64;
  localparam int DW     = 32;
  localparam int BW     = 16;
  localparam int LINE_B = BW * DW / 8;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  instr_cache_line_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) bus();

  instr_cache_line_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
    .clk(clk),
    .arst(arst),
    .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            ar_delay;
    int            gap_mode;
    int            err_beat;
    int            last_beat;
    logic          stray;
    logic [AW-1:0] exp_araddr;
    logic          exp_err;
  } vec_t;

  vec_t tbl[6];

  int nvec  = 0;
  int nfail = 0;

  logic [DW-1:0]          bdata[BW];
  logic [1:0]             bresp[BW];
  logic                   blast[BW];
  int                     bgap[BW];
  logic [BW-1:0][DW-1:0]  ref_line = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_line(input string nm, input logic [BW*DW-1:0] act,
                          input logic [BW*DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic model_err();
    logic e = 1'b0;
    for (int k = 0; k < BW; k++)
      if (bresp[k][1] || (blast[k] != (k == BW - 1))) e = 1'b1;
    return e;
  endfunction

  function automatic logic [AW-1:0] model_align(input logic [AW-1:0] a);
    return (a / LINE_B) * LINE_B;
  endfunction

  // Entered and left on a negedge; abort_after >= 0 resets the DUT after that beat.
  task automatic run_burst(input logic [AW-1:0] addr, input int ar_delay, input logic stray,
                           input logic [AW-1:0] exp_araddr, input logic exp_err,
                           input int abort_after);
    bus.i_start_read = 1'b1;
    bus.i_addr       = addr;
    @(negedge clk);
    bus.i_addr = ~addr;
    for (int c = 0; c <= ar_delay; c++) begin
      chk("arvalid_addr", 64'(bus.o_arvalid), 64'd1);
      chk("araddr", bus.o_araddr, exp_araddr);
      chk("rready_addr", 64'(bus.o_rready), 64'd0);
      if (c == 0) begin
        chk("arlen", 64'(bus.o_arlen), 64'(BW - 1));
        chk("arsize", 64'(bus.o_arsize), 64'd2);
        chk("arburst", 64'(bus.o_arburst), 64'd1);
      end
      bus.i_arready = (c == ar_delay);
      bus.i_rvalid  = stray;
      bus.i_rdata   = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    bus.i_arready = 1'b0;
    bus.i_rvalid  = 1'b0;
    chk("arvalid_data", 64'(bus.o_arvalid), 64'd0);
    chk("rready_data", 64'(bus.o_rready), 64'd1);
    chk_line("line_held", bus.o_line_data, ref_line);
    for (int k = 0; k < BW; k++) begin
      for (int g = 0; g < bgap[k]; g++) begin
        @(negedge clk);
        chk("r_last_gap", 64'(bus.o_r_last), 64'd0);
      end
      bus.i_rvalid = 1'b1;
      bus.i_rdata  = bdata[k];
      bus.i_rresp  = bresp[k];
      bus.i_rlast  = blast[k];
      @(negedge clk);
      bus.i_rvalid = 1'b0;
      bus.i_rlast  = 1'b0;
      bus.i_rresp  = 2'b00;
      ref_line[k]  = bdata[k];
      chk("beat_word", 64'(bus.o_line_data[k*DW +: DW]), 64'(bdata[k]));
      if (k == abort_after) begin
        arst = 1'b1;
        #1;
        chk("rst_rready", 64'(bus.o_rready), 64'd0);
        chk("rst_arvalid", 64'(bus.o_arvalid), 64'd0);
        ref_line = '0;
        chk_line("rst_line", bus.o_line_data, ref_line);
        bus.i_start_read = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        return;
      end
      if (k < BW - 1) chk("r_last_early", 64'(bus.o_r_last), 64'd0);
    end
    chk("r_last", 64'(bus.o_r_last), 64'd1);
    chk("error", 64'(bus.o_error), 64'(exp_err));
    chk("rready_done", 64'(bus.o_rready), 64'd0);
    chk_line("line_done", bus.o_line_data, ref_line);
    bus.i_start_read = 1'b0;
    @(negedge clk);
    chk("r_last_pulse", 64'(bus.o_r_last), 64'd0);
    chk("error_after", 64'(bus.o_error), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    tbl[0] = '{64'h0000_0000_1000_0044, 0, 0, -1, 15, 1'b0, 64'h0000_0000_1000_0040, 1'b0};
    tbl[1] = '{64'h0000_0000_2000_00FC, 5, 0, -1, 15, 1'b1, 64'h0000_0000_2000_00C0, 1'b0};
    tbl[2] = '{64'h0000_0000_3000_0000, 1, 1, -1, 15, 1'b0, 64'h0000_0000_3000_0000, 1'b0};
    tbl[3] = '{64'h0000_0000_4000_007F, 0, 0,  3, 15, 1'b0, 64'h0000_0000_4000_0040, 1'b1};
    tbl[4] = '{64'h0000_0000_5000_0010, 0, 0, -1, 10, 1'b0, 64'h0000_0000_5000_0000, 1'b1};
    tbl[5] = '{64'hFFFF_FFFF_FFFF_FFC5, 0, 0, -1, 15, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0};

    bus.i_start_read = 1'b0;
    bus.i_addr       = '0;
    bus.i_arready    = 1'b0;
    bus.i_rvalid     = 1'b0;
    bus.i_rdata      = '0;
    bus.i_rresp      = 2'b00;
    bus.i_rlast      = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_arvalid0", 64'(bus.o_arvalid), 64'd0);
    chk("rst_rready0", 64'(bus.o_rready), 64'd0);
    chk("rst_r_last0", 64'(bus.o_r_last), 64'd0);
    chk("rst_error0", 64'(bus.o_error), 64'd0);
    chk("rst_araddr0", bus.o_araddr, 64'd0);
    chk_line("rst_line0", bus.o_line_data, '0);
    arst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < BW; k++) begin
        bdata[k] = (i == 0) ? 32'(32'hA0 + k) : 32'(32'hD000_0000 + (i << 8) + k);
        bresp[k] = (k == tbl[i].err_beat) ? 2'b10 : 2'b00;
        blast[k] = (k == tbl[i].last_beat);
        bgap[k]  = (tbl[i].gap_mode != 0 && k > 0) ? 2 : 0;
      end
      run_burst(tbl[i].addr, tbl[i].ar_delay, tbl[i].stray, tbl[i].exp_araddr,
                tbl[i].exp_err, -1);
    end

    for (int k = 0; k < BW; k++) begin
      bdata[k] = 32'(32'hC0DE_0000 + k);
      bresp[k] = 2'b00;
      blast[k] = (k == BW - 1);
      bgap[k]  = 0;
    end
    run_burst(64'h0000_0000_6000_0088, 0, 1'b0, 64'h0000_0000_6000_0080, 1'b0, 7);

    for (int r = 0; r < 14; r++) begin
      ra = {$urandom, $urandom};
      for (int k = 0; k < BW; k++) begin
        bdata[k] = $urandom;
        bresp[k] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        blast[k] = (k == BW - 1) ^ ($urandom_range(0, 39) == 0);
        bgap[k]  = $urandom_range(0, 2);
      end
      run_burst(ra, $urandom_range(0, 3), 1'($urandom_range(0, 1)), model_align(ra),
                model_err(), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
